// File: rtl/tetris_pkg.sv
// ============================================================================
// Module   : tetris_pkg
// Purpose  : Shared types, board geometry constants and helpers for the
//            4x8 Tetris controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tetris_pkg;

  localparam int          ROWS      = 8;
  localparam int          COLS      = 4;
  localparam logic [3:0]  FULL_ROW  = 4'hF;
  localparam logic [31:0] TOP_MASK  = 32'h0000_00FF;
  localparam logic [3:0]  LFSR_SEED = 4'b1001;
  localparam logic [3:0]  LFSR_TAPS = 4'b1100;  // x^4 + x^3 + 1

  typedef enum logic [2:0] {
    ST_SPAWN     = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CLEAR     = 3'd4,
    ST_OVER      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_LEFT   = 2'd1,
    CMD_RIGHT  = 2'd2,
    CMD_ROTATE = 2'd3
  } cmd_t;

  function automatic logic [3:0] lfsr_next(input logic [3:0] cur);
    return {cur[2:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Remove row 'row': rows above it slide down one, row 0 becomes empty.
  function automatic logic [31:0] drop_row(input logic [31:0] board, input logic [2:0] row);
    logic [31:0] low_rows;
    low_rows = 32'hFFFF_FFFF >> (5'd28 - {row, 2'b00});
    return (board & ~low_rows) | ((board << COLS) & low_rows);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tetris_input_latch.sv
// ============================================================================
// Module   : tetris_input_latch
// Purpose  : Button rising-edge detect with a single-entry pending command.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tetris_input_latch
  import tetris_pkg::*;
(
  input  logic clka,
  input  logic reset,
  input  logic enable,
  input  logic consume,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rotate,
  output cmd_t pending
);

  logic [2:0] prev_btn;
  logic [2:0] rise;
  cmd_t       rise_cmd;

  assign rise = {btn_left, btn_right, btn_rotate} & ~prev_btn;

  always_comb begin
    rise_cmd = CMD_NONE;
    if (rise[2])      rise_cmd = CMD_LEFT;
    else if (rise[1]) rise_cmd = CMD_RIGHT;
    else if (rise[0]) rise_cmd = CMD_ROTATE;
  end

  // A fresh edge beats consumption so a press during ISSUE survives.
  always_ff @(posedge clka) begin
    if (reset) begin
      prev_btn <= 3'b000;
      pending  <= CMD_NONE;
    end else begin
      prev_btn <= {btn_left, btn_right, btn_rotate};
      if (enable && (rise_cmd != CMD_NONE)) pending <= rise_cmd;
      else if (consume)                     pending <= CMD_NONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tetris_game_ctrl.sv
// ============================================================================
// Module   : tetris_game_ctrl
// Purpose  : Game sequencer: spawn, gravity/move requests, row clear, score.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int TICK_CYCLES = 16,
  parameter int SPAWN_LOC   = 5
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  output logic        move_start,
  output logic        move_left,
  output logic        move_right,
  output logic        move_rotate,
  output logic [1:0]  piece_type,
  output logic [4:0]  piece_loc,
  output logic [1:0]  piece_rot,
  output logic [31:0] board_state,
  input  logic        move_done,
  input  logic        move_touched,
  input  logic [4:0]  move_new_loc,
  input  logic [1:0]  move_new_rot,
  input  logic [31:0] move_new_board,
  output logic [7:0]  score,
  output logic        game_over
);

  localparam int            CW        = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    row_ptr;
  logic [3:0]    lfsr;
  cmd_t          pending;
  logic          row_full;
  logic          top_blocked;

  assign row_full    = (board_state[{row_ptr, 2'b00} +: 4] == FULL_ROW);
  assign top_blocked = |(board_state & TOP_MASK);

  tetris_input_latch u_input_latch (
    .clka       (clka),
    .reset      (reset),
    .enable     (state != ST_OVER),
    .consume    (state == ST_ISSUE),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_rotate (btn_rotate),
    .pending    (pending)
  );

  always_ff @(posedge clka) begin
    if (reset) state <= ST_SPAWN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_SPAWN:     state_nx = top_blocked ? ST_OVER : ST_WAIT_TICK;
      ST_WAIT_TICK: if (tick_cnt == TICK_LAST) state_nx = ST_ISSUE;
      ST_ISSUE:     state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: if (move_done) state_nx = move_touched ? ST_CLEAR : ST_WAIT_TICK;
      ST_CLEAR:     if (!row_full && (row_ptr == 3'd0)) state_nx = ST_SPAWN;
      ST_OVER:      state_nx = ST_OVER;
      default:      state_nx = ST_SPAWN;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      board_state <= 32'h0;
      score       <= 8'h00;
      game_over   <= 1'b0;
      piece_type  <= 2'd0;
      piece_loc   <= 5'd0;
      piece_rot   <= 2'd0;
      move_start  <= 1'b0;
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      move_rotate <= 1'b0;
      tick_cnt    <= '0;
      row_ptr     <= 3'(ROWS - 1);
      lfsr        <= LFSR_SEED;
    end else begin
      move_start  <= 1'b0;
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      move_rotate <= 1'b0;
      if (state != ST_OVER) lfsr <= lfsr_next(lfsr);

      case (state)
        ST_SPAWN: begin
          if (top_blocked) begin
            game_over <= 1'b1;
          end else begin
            piece_type <= lfsr[1:0];
            piece_loc  <= 5'(SPAWN_LOC);
            piece_rot  <= 2'd0;
            tick_cnt   <= '0;
          end
        end
        ST_WAIT_TICK: tick_cnt <= tick_cnt + CW'(1);
        ST_ISSUE: begin
          move_start  <= 1'b1;
          move_left   <= (pending == CMD_LEFT);
          move_right  <= (pending == CMD_RIGHT);
          move_rotate <= (pending == CMD_ROTATE);
        end
        ST_WAIT_DONE: begin
          if (move_done) begin
            piece_loc   <= move_new_loc;
            piece_rot   <= move_new_rot;
            board_state <= move_new_board;
            if (move_touched) row_ptr  <= 3'(ROWS - 1);
            else              tick_cnt <= '0;
          end
        end
        // Row pointer stays put after a clear so the row that slid in is rechecked.
        ST_CLEAR: begin
          if (row_full) begin
            board_state <= drop_row(board_state, row_ptr);
            if (score != 8'hFF) score <= score + 8'd1;
          end else if (row_ptr != 3'd0) begin
            row_ptr <= row_ptr - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
